// File: rtl/prog_store_pkg.sv
// prog_store_pkg: shared definitions for the writable program store.
//   - default fetch-address and instruction widths
//   - load-session FSM state encoding (RUN, LOAD, RELEASE)
//   - helper to derive bytes per instruction word
package prog_store_pkg;

   localparam int PC_LEN_DEF    = 8;
   localparam int INSTR_LEN_DEF = 16;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LOAD    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   // Bytes needed to carry one instruction word, rounded up.
   function automatic int nbytes(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/prog_store_mem.sv
// prog_store_mem: DEPTH x W instruction array.
//   clk    : write clock
//   we     : write enable, word written on rising clk edge
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (asynchronous read)
//   rdata  : word at raddr, combinational
// No reset on the array; the owner gates reads of unwritten words.
// Kept as its own module so a foundry memory macro can replace it later.
module prog_store_mem #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int W     = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_store.sv
// prog_store: writable program store for the core's fetch port, filled
// through a byte-serial load port.
//   CLK, RSTN         : clock, asynchronous active-low reset
//   PC / INSTR        : fetch address in, instruction out (combinational)
//   LD_EN             : load-session request (level)
//   LD_VALID/LD_DATA  : load byte offered by the source
//   LD_READY          : byte accepted this cycle when LD_VALID is also high
//   LD_DONE           : one-cycle pulse as a session ends
//   LD_ERR            : sticky; last session left a partial word or overflowed
//   WCOUNT            : number of valid words loaded
//   CORE_RSTN         : registered active-low reset to the core
//   DBG_STATE         : current FSM state, for observation
// Load handshake: a byte transfers on a rising edge where LD_VALID and
// LD_READY are both high; LD_READY never depends on LD_VALID, and the source
// holds LD_DATA stable while LD_VALID is high and LD_READY is low.
module prog_store
   import prog_store_pkg::*;
#(
   parameter int PC_LEN    = PC_LEN_DEF,
   parameter int INSTR_LEN = INSTR_LEN_DEF,
   parameter int DEPTH     = 2 ** PC_LEN
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic [PC_LEN-1:0]    PC,
   output logic [INSTR_LEN-1:0] INSTR,
   input  logic                 LD_EN,
   input  logic                 LD_VALID,
   input  logic [7:0]           LD_DATA,
   output logic                 LD_READY,
   output logic                 LD_DONE,
   output logic                 LD_ERR,
   output logic [PC_LEN:0]      WCOUNT,
   output logic                 CORE_RSTN,
   output logic [1:0]           DBG_STATE
);

   localparam int NBYTES = nbytes(INSTR_LEN);
   localparam int ASM_W  = NBYTES * 8;
   localparam int BC_W   = $clog2(NBYTES + 1);
   localparam logic [PC_LEN:0] DEPTH_W = (PC_LEN + 1)'(DEPTH);
   localparam logic [BC_W-1:0] LAST_BC = BC_W'(NBYTES - 1);

   state_t              state_q, state_d;
   logic                core_rstn_q;
   logic [PC_LEN:0]     wcount_q;
   logic                err_q;
   logic [BC_W-1:0]     bc_q, bc_after;
   logic [ASM_W-1:0]    asm_q, asm_d;
   logic                room, accept, last_byte, we;
   logic [INSTR_LEN-1:0] rdata;

   // Shift the new byte in at the bottom; after NBYTES bytes the first byte
   // sits in the top byte and the low INSTR_LEN bits form the word.
   assign asm_d     = (asm_q << 8) | ASM_W'(LD_DATA);
   assign room      = (wcount_q < DEPTH_W);
   assign accept    = LD_VALID && LD_READY;
   assign last_byte = (bc_q == LAST_BC);
   assign we        = accept && last_byte;

   // Byte count as it stands after this cycle's acceptance; used to judge a
   // partial word when the session ends in the same cycle.
   always_comb begin
      bc_after = bc_q;
      if (accept) begin
         bc_after = last_byte ? '0 : bc_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      LD_READY = 1'b0;
      LD_DONE  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (LD_EN) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            LD_READY = room;
            if (!LD_EN) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            LD_DONE = 1'b1;
            state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= ST_RUN;
         core_rstn_q <= 1'b0;
         wcount_q    <= '0;
         err_q       <= 1'b0;
         bc_q        <= '0;
         asm_q       <= '0;
      end else begin
         state_q     <= state_d;
         core_rstn_q <= (state_d == ST_RUN);
         case (state_q)
            ST_RUN: begin
               if (LD_EN) begin
                  wcount_q <= '0;
                  bc_q     <= '0;
                  err_q    <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  asm_q <= asm_d;
                  bc_q  <= bc_after;
                  if (last_byte) wcount_q <= wcount_q + 1'b1;
               end
               if (LD_VALID && !room) err_q <= 1'b1;
               if (!LD_EN && (bc_after != '0)) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   prog_store_mem #(
      .DEPTH (DEPTH),
      .AW    (PC_LEN),
      .W     (INSTR_LEN)
   ) u_mem (
      .clk   (CLK),
      .we    (we),
      .waddr (wcount_q[PC_LEN-1:0]),
      .wdata (asm_d[INSTR_LEN-1:0]),
      .raddr (PC),
      .rdata (rdata)
   );

   // Words at or beyond WCOUNT read as zero, hiding stale array contents.
   assign INSTR     = ({1'b0, PC} < wcount_q) ? rdata : '0;
   assign LD_ERR    = err_q;
   assign WCOUNT    = wcount_q;
   assign CORE_RSTN = core_rstn_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_prog_store.sv
module tb_prog_store;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [1:0]  PC;
   logic [15:0] INSTR;
   logic        LD_EN, LD_VALID;
   logic [7:0]  LD_DATA;
   logic        LD_READY, LD_DONE, LD_ERR, CORE_RSTN;
   logic [2:0]  WCOUNT;
   logic [1:0]  DBG_STATE;

   int n_checks = 0;
   int n_pass   = 0;

   prog_store #(.PC_LEN(2), .INSTR_LEN(16), .DEPTH(4)) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .PC        (PC),
      .INSTR     (INSTR),
      .LD_EN     (LD_EN),
      .LD_VALID  (LD_VALID),
      .LD_DATA   (LD_DATA),
      .LD_READY  (LD_READY),
      .LD_DONE   (LD_DONE),
      .LD_ERR    (LD_ERR),
      .WCOUNT    (WCOUNT),
      .CORE_RSTN (CORE_RSTN),
      .DBG_STATE (DBG_STATE)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1ns later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Offer one byte and hold it until accepted (bounded).
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      LD_VALID = 1'b1;
      LD_DATA  = b;
      while (!LD_READY && n < 20) begin
         step();
         n++;
      end
      if (!LD_READY) chk("send_timeout", 32'(LD_READY), 32'd1);
      step();
      LD_VALID = 1'b0;
   endtask

   task automatic end_session();
      LD_EN = 1'b0;
      step();
      step();
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
      PC = a;
      #1;
      chk(tag, 32'(INSTR), 32'(exp));
   endtask

   initial begin
      RSTN = 1'b0; PC = '0; LD_EN = 1'b0; LD_VALID = 1'b0; LD_DATA = '0;
      #12;
      chk("rst_core_rstn", 32'(CORE_RSTN), 32'd0);
      chk("rst_wcount",    32'(WCOUNT),    32'd0);
      chk("rst_ready",     32'(LD_READY),  32'd0);
      chk("rst_done",      32'(LD_DONE),   32'd0);
      chk("rst_err",       32'(LD_ERR),    32'd0);
      RSTN = 1'b1;
      step();
      chk("run_core_rstn", 32'(CORE_RSTN), 32'd1);

      // Basic load: 12 34 56 78 AB CD
      LD_EN = 1'b1;
      step();
      chk("ld_core_rstn", 32'(CORE_RSTN), 32'd0);
      chk("ld_ready",     32'(LD_READY),  32'd1);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      send_byte(8'h78); send_byte(8'hAB); send_byte(8'hCD);
      LD_EN = 1'b0;
      step();
      chk("basic_done_hi",  32'(LD_DONE),   32'd1);
      chk("basic_rel_core", 32'(CORE_RSTN), 32'd0);
      step();
      chk("basic_done_lo",  32'(LD_DONE),   32'd0);
      chk("basic_core",     32'(CORE_RSTN), 32'd1);
      chk("basic_wcount",   32'(WCOUNT),    32'd3);
      chk("basic_err",      32'(LD_ERR),    32'd0);
      rd("basic_pc0", 2'd0, 16'h1234);
      rd("basic_pc1", 2'd1, 16'h5678);
      rd("basic_pc2", 2'd2, 16'hABCD);
      rd("basic_pc3", 2'd3, 16'h0000);

      // Partial word
      LD_EN = 1'b1;
      step();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      end_session();
      chk("part_wcount", 32'(WCOUNT), 32'd1);
      chk("part_err",    32'(LD_ERR), 32'd1);
      rd("part_pc0", 2'd0, 16'h1122);
      rd("part_pc1", 2'd1, 16'h0000);

      // Overflow: 8 bytes fill DEPTH, then 09 and 0A are dropped
      LD_EN = 1'b1;
      step();
      chk("ovf_err_clr", 32'(LD_ERR), 32'd0);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      chk("ovf_ready",  32'(LD_READY), 32'd0);
      chk("ovf_wcount", 32'(WCOUNT),   32'd4);
      chk("ovf_err_pre", 32'(LD_ERR),  32'd0);
      LD_VALID = 1'b1; LD_DATA = 8'h09;
      step();
      chk("ovf_err", 32'(LD_ERR), 32'd1);
      LD_DATA = 8'h0A;
      step();
      LD_VALID = 1'b0;
      end_session();
      chk("ovf_wcount_end", 32'(WCOUNT), 32'd4);
      chk("ovf_err_end",    32'(LD_ERR), 32'd1);
      rd("ovf_pc0", 2'd0, 16'h0102);
      rd("ovf_pc3", 2'd3, 16'h0708);

      // Back-pressure: LD_VALID every other cycle
      LD_EN = 1'b1;
      step();
      begin
         logic [7:0] bp [4];
         bp[0] = 8'hDE; bp[1] = 8'hAD; bp[2] = 8'hBE; bp[3] = 8'hEF;
         for (int i = 0; i < 4; i++) begin
            LD_VALID = 1'b1; LD_DATA = bp[i];
            step();
            chk("bp_core_a", 32'(CORE_RSTN), 32'd0);
            LD_VALID = 1'b0; LD_DATA = 8'hFF;
            step();
            chk("bp_core_b", 32'(CORE_RSTN), 32'd0);
         end
      end
      end_session();
      chk("bp_wcount", 32'(WCOUNT), 32'd2);
      chk("bp_err",    32'(LD_ERR), 32'd0);
      rd("bp_pc0", 2'd0, 16'hDEAD);
      rd("bp_pc1", 2'd1, 16'hBEEF);
      rd("bp_pc2", 2'd2, 16'h0000);

      // Reset mid-load after 3 bytes
      LD_EN = 1'b1;
      step();
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
      RSTN = 1'b0;
      #1;
      chk("mrst_core",   32'(CORE_RSTN), 32'd0);
      chk("mrst_wcount", 32'(WCOUNT),    32'd0);
      LD_EN = 1'b0;
      step();
      RSTN = 1'b1;
      #1;
      chk("mrst_core_rel", 32'(CORE_RSTN), 32'd0);
      step();
      chk("mrst_core_run", 32'(CORE_RSTN), 32'd1);
      for (int a = 0; a < 4; a++) rd("mrst_rd", 2'(a), 16'h0000);

      // Last byte coincident with LD_EN falling
      LD_EN = 1'b1;
      step();
      send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
      LD_VALID = 1'b1; LD_DATA = 8'hD4; LD_EN = 1'b0;
      step();
      LD_VALID = 1'b0;
      chk("coin_done", 32'(LD_DONE), 32'd1);
      step();
      chk("coin_wcount", 32'(WCOUNT), 32'd2);
      chk("coin_err",    32'(LD_ERR), 32'd0);
      rd("coin_pc0", 2'd0, 16'hA1B2);
      rd("coin_pc1", 2'd1, 16'hC3D4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, required finish");
      $fatal(1);
   end

endmodule
